// File: rtl/frame_spi_writer.sv
// Serialises {Adress, Mod_SEL, D} as a 32-bit SPI mode-0 frame, MSB first, with an
// optional trigger pulse after each frame and a one-deep pending request slot.
module frame_spi_writer #(
  parameter logic [15:0] CLK_DIV = 16'd4,
  parameter logic [7:0]  TRP_LEN = 8'd8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        received_done,
  input  logic [1:0]  Adress,
  input  logic [5:0]  Mod_SEL,
  input  logic [23:0] D,
  input  logic        TRP,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        trp_out,
  output logic        busy,
  output logic        wr_done,
  output logic        overflow
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  half_q, half_d;
  logic [31:0] shreg_q, shreg_d;
  logic        trp_q, trp_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_frame_q, pend_frame_d;
  logic        pend_trp_q, pend_trp_d;
  logic        wr_done_q, wr_done_d;
  logic        ovf_q, ovf_d;

  logic div_end, gap_end, consume;

  assign div_end = (cnt_q == CLK_DIV - 16'd1);
  assign gap_end = (cnt_q == {8'd0, TRP_LEN} - 16'd1);
  assign consume = (state_q == GAP) && gap_end && pend_v_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    shreg_d      = shreg_q;
    trp_d        = trp_q;
    pend_v_d     = pend_v_q;
    pend_frame_d = pend_frame_q;
    pend_trp_d   = pend_trp_q;
    wr_done_d    = 1'b0;
    ovf_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (received_done) begin
          state_d = SETUP;
          shreg_d = {Adress, Mod_SEL, D};
          trp_d   = TRP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SHIFT;
          cnt_d   = '0;
          half_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      SHIFT: begin
        // Even half-periods are SCLK low, odd are high; data advances as a high phase ends.
        if (div_end) begin
          cnt_d = '0;
          if (half_q == 6'd63) begin
            state_d = HOLD;
          end else begin
            half_d = half_q + 6'd1;
            if (half_q[0]) shreg_d = {shreg_q[30:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d   = GAP;
          cnt_d     = '0;
          wr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (gap_end) begin
          cnt_d = '0;
          if (pend_v_q) begin
            state_d  = SETUP;
            shreg_d  = pend_frame_q;
            trp_d    = pend_trp_q;
            pend_v_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A slot being consumed this cycle can be refilled in the same cycle.
    if (received_done && (state_q != IDLE || pend_v_q)) begin
      if (!pend_v_q || consume) begin
        pend_v_d     = 1'b1;
        pend_frame_d = {Adress, Mod_SEL, D};
        pend_trp_d   = TRP;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      half_q       <= '0;
      shreg_q      <= '0;
      trp_q        <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_frame_q <= '0;
      pend_trp_q   <= 1'b0;
      wr_done_q    <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      shreg_q      <= shreg_d;
      trp_q        <= trp_d;
      pend_v_q     <= pend_v_d;
      pend_frame_q <= pend_frame_d;
      pend_trp_q   <= pend_trp_d;
      wr_done_q    <= wr_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign spi_cs_n = !((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD));
  assign spi_sclk = (state_q == SHIFT) && half_q[0];
  assign spi_mosi = shreg_q[31];
  assign trp_out  = (state_q == GAP) && trp_q;
  assign busy     = (state_q != IDLE) || pend_v_q;
  assign wr_done  = wr_done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_frame_spi_writer.sv
// Scoreboard bench for frame_spi_writer with CLK_DIV=4, TRP_LEN=8.
module tb_frame_spi_writer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        received_done;
  logic [1:0]  Adress;
  logic [5:0]  Mod_SEL;
  logic [23:0] D;
  logic        TRP;
  logic        spi_cs_n, spi_sclk, spi_mosi, trp_out, busy, wr_done, overflow;

  frame_spi_writer #(.CLK_DIV(16'd4), .TRP_LEN(8'd8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .received_done(received_done),
    .Adress(Adress), .Mod_SEL(Mod_SEL), .D(D), .TRP(TRP),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .trp_out(trp_out), .busy(busy), .wr_done(wr_done), .overflow(overflow)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] frame;
    logic        trp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  int bits = 0, low_cnt = 0, hi_run = 0, last_gap = 0;
  int trp_run = 0, last_trp_run = 0, trp_cyc = 0, wr_cnt = 0, ovf_cnt = 0;
  logic [31:0] shift_in = '0;
  logic prev_csn = 1'b1, prev_sclk = 1'b0, prev_trp = 1'b0;

  // Frame monitor: decodes the SPI line and checks each completed frame against the scoreboard.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      bits = 0; low_cnt = 0; trp_run = 0; hi_run = 0;
      prev_csn = 1'b1; prev_sclk = 1'b0; prev_trp = 1'b0;
    end else begin
      if (wr_done) wr_cnt++;
      if (overflow) ovf_cnt++;
      if (trp_out) begin
        trp_run++; trp_cyc++;
      end else if (prev_trp) begin
        last_trp_run = trp_run; trp_run = 0;
      end
      if (!spi_cs_n) begin
        if (prev_csn) last_gap = hi_run;
        low_cnt++;
        if (spi_sclk && !prev_sclk) begin
          shift_in = {shift_in[30:0], spi_mosi};
          bits++;
        end
      end else begin
        hi_run = prev_csn ? hi_run + 1 : 1;
        if (!prev_csn) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected_frame got %h expected none", shift_in);
          end else begin
            mon_e = sb.pop_front();
            checks += 5;
            if (shift_in !== mon_e.frame) begin
              errors++; $display("FAIL frame_data got %h expected %h", shift_in, mon_e.frame);
            end
            if (bits !== 32) begin
              errors++; $display("FAIL frame_bits got %0d expected 32", bits);
            end
            if (low_cnt !== 264) begin
              errors++; $display("FAIL cs_low_len got %0d expected 264", low_cnt);
            end
            if (wr_done !== 1'b1) begin
              errors++; $display("FAIL wr_done_at_cs_rise got %b expected 1", wr_done);
            end
            if (trp_out !== mon_e.trp) begin
              errors++; $display("FAIL trp_at_cs_rise got %b expected %b", trp_out, mon_e.trp);
            end
          end
          bits = 0; low_cnt = 0;
        end
      end
      prev_csn = spi_cs_n; prev_sclk = spi_sclk; prev_trp = trp_out;
    end
  end

  task automatic send(input logic [1:0] a, input logic [5:0] m, input logic [23:0] d,
                      input logic t, input bit push);
    exp_t e;
    @(negedge sys_clk);
    Adress = a; Mod_SEL = m; D = d; TRP = t; received_done = 1'b1;
    if (push) begin
      e.frame = {a, m, d};
      e.trp   = t;
      sb.push_back(e);
    end
    @(negedge sys_clk);
    received_done = 1'b0;
    Adress = '0; Mod_SEL = '0; D = '0; TRP = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || !spi_cs_n) && n < 3000) begin
      @(negedge sys_clk); n++;
    end
    repeat (2) @(negedge sys_clk);
    checks += 2;
    if (n >= 3000) begin
      errors++; $display("FAIL %s_idle_timeout got %0d cycles expected <3000", name, n);
    end
    if (sb.size() != 0) begin
      errors++; $display("FAIL %s_frames_missing got %0d pending expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks += 2;
    if ({spi_cs_n, spi_sclk, spi_mosi, trp_out} !== 4'b1000) begin
      errors++; $display("FAIL reset_spi got %b expected 1000", {spi_cs_n, spi_sclk, spi_mosi, trp_out});
    end
    if ({busy, wr_done, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b expected 000", {busy, wr_done, overflow});
    end
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_single();
    int w0 = wr_cnt, t0 = trp_cyc;
    send(2'b01, 6'h2A, 24'hA5F00F, 1'b0, 1'b1);
    checks++;
    if (spi_cs_n !== 1'b0 || spi_mosi !== 1'b0) begin
      errors++; $display("FAIL single_start got cs_n=%b mosi=%b expected 0 0", spi_cs_n, spi_mosi);
    end
    wait_idle("single");
    checks += 2;
    if (wr_cnt - w0 !== 1) begin
      errors++; $display("FAIL single_wr_done got %0d expected 1", wr_cnt - w0);
    end
    if (trp_cyc - t0 !== 0) begin
      errors++; $display("FAIL single_trp got %0d expected 0", trp_cyc - t0);
    end
  endtask

  task automatic test_trp();
    int w0 = wr_cnt, t0 = trp_cyc;
    send(2'b01, 6'h2A, 24'hA5F00F, 1'b1, 1'b1);
    repeat (20) @(negedge sys_clk);
    send(2'b10, 6'h15, 24'h123456, 1'b1, 1'b1);
    wait_idle("trp");
    checks += 4;
    if (last_trp_run !== 8) begin
      errors++; $display("FAIL trp_width got %0d expected 8", last_trp_run);
    end
    if (last_gap !== 8) begin
      errors++; $display("FAIL trp_gap got %0d expected 8", last_gap);
    end
    if (trp_cyc - t0 !== 16) begin
      errors++; $display("FAIL trp_total got %0d expected 16", trp_cyc - t0);
    end
    if (wr_cnt - w0 !== 2) begin
      errors++; $display("FAIL trp_wr_done got %0d expected 2", wr_cnt - w0);
    end
  endtask

  task automatic test_overflow();
    int w0 = wr_cnt, o0 = ovf_cnt;
    send(2'b11, 6'h3F, 24'hFFFFFF, 1'b0, 1'b1);
    repeat (8) @(negedge sys_clk);
    send(2'b00, 6'h01, 24'h000001, 1'b0, 1'b1);
    repeat (8) @(negedge sys_clk);
    send(2'b10, 6'h20, 24'h800000, 1'b1, 1'b0);
    wait_idle("overflow");
    checks += 2;
    if (ovf_cnt - o0 !== 1) begin
      errors++; $display("FAIL overflow_count got %0d expected 1", ovf_cnt - o0);
    end
    if (wr_cnt - w0 !== 2) begin
      errors++; $display("FAIL overflow_wr_done got %0d expected 2", wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, o0 = ovf_cnt, n = 0;
    send(2'b01, 6'h0F, 24'h0F0F0F, 1'b0, 1'b1);
    repeat (8) @(negedge sys_clk);
    send(2'b10, 6'h30, 24'hC3C3C3, 1'b1, 1'b1);
    while (!spi_cs_n && n < 1000) begin
      @(negedge sys_clk); n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++; $display("FAIL b2b_cs_rise_timeout got %0d expected <1000", n);
    end
    repeat (6) @(negedge sys_clk);
    send(2'b00, 6'h2B, 24'h5A5A5A, 1'b0, 1'b1);
    checks++;
    if (spi_cs_n !== 1'b0) begin
      errors++; $display("FAIL b2b_pending_start got cs_n=%b expected 0", spi_cs_n);
    end
    wait_idle("b2b");
    checks += 2;
    if (ovf_cnt - o0 !== 0) begin
      errors++; $display("FAIL b2b_overflow got %0d expected 0", ovf_cnt - o0);
    end
    if (wr_cnt - w0 !== 3) begin
      errors++; $display("FAIL b2b_wr_done got %0d expected 3", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_midframe();
    int w0 = wr_cnt, t0 = trp_cyc, n = 0;
    send(2'b11, 6'h11, 24'hDEADBE, 1'b1, 1'b0);
    while (bits < 12 && n < 2000) begin
      @(negedge sys_clk); n++;
    end
    #2 sys_rst = 1'b1;
    #1;
    checks += 2;
    if (n >= 2000) begin
      errors++; $display("FAIL rstmid_bit_timeout got %0d expected <2000", n);
    end
    if ({spi_cs_n, spi_sclk, busy} !== 3'b100) begin
      errors++; $display("FAIL rstmid_async got %b expected 100", {spi_cs_n, spi_sclk, busy});
    end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);
    checks += 2;
    if (wr_cnt - w0 !== 0) begin
      errors++; $display("FAIL rstmid_wr_done got %0d expected 0", wr_cnt - w0);
    end
    if (trp_cyc - t0 !== 0) begin
      errors++; $display("FAIL rstmid_trp got %0d expected 0", trp_cyc - t0);
    end
    send(2'b01, 6'h2A, 24'hA5F00F, 1'b0, 1'b1);
    wait_idle("rstmid");
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++; $display("FAIL rstmid_after_wr_done got %0d expected 1", wr_cnt - w0);
    end
  endtask

  initial begin
    sys_rst = 1'b1; received_done = 1'b0;
    Adress = '0; Mod_SEL = '0; D = '0; TRP = 1'b0;
    test_reset();
    test_single();
    test_trp();
    test_overflow();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_spi_writer.md
FRAME_SPI_WRITER -- requirements
Module: frame_spi_writer

Interface
REQ-001 Parameter CLK_DIV, default 16'd4, SCLK half-period in sys_clk cycles; legal range 2..65535.
REQ-002 Parameter TRP_LEN, default 8'd8, trigger pulse width and minimum inter-frame gap in sys_clk cycles; legal range 1..255.
REQ-003 sys_clk  input  1  single clock for all logic.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 received_done  input  1  one-cycle pulse; Adress/Mod_SEL/D/TRP are valid in the same cycle.
REQ-006 Adress  input  2  target channel address.
REQ-007 Mod_SEL  input  6  mode select field.
REQ-008 D  input  24  data word.
REQ-009 TRP  input  1  request a trigger pulse after this frame.
REQ-010 spi_cs_n  output  1  frame select, active low.
REQ-011 spi_sclk  output  1  serial clock, idle low (mode 0).
REQ-012 spi_mosi  output  1  serial data, MSB first.
REQ-013 trp_out  output  1  update/trigger pulse to external device.
REQ-014 busy  output  1  high while a frame is active or a request is pending.
REQ-015 wr_done  output  1  one-cycle pulse per completed frame.
REQ-016 overflow  output  1  one-cycle pulse when a request is dropped.

Function
REQ-017 The frame word SHALL be {Adress, Mod_SEL, D}: 32 bits, bit 31 shifted first.
REQ-018 The request latch SHALL capture Adress, Mod_SEL, D and TRP on every accepted received_done; inputs are not sampled at any other time.
REQ-019 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-020 IDLE with no pending request, received_done=1: next cycle state=SETUP, spi_cs_n=0, spi_sclk=0, spi_mosi=frame bit 31.
REQ-021 SETUP SHALL last CLK_DIV cycles, then transition to SHIFT.
REQ-022 SHIFT, per bit: spi_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles; spi_mosi changes only at the start of a low phase and is stable while high; 32 bits = 64*CLK_DIV cycles.
REQ-023 After bit 0's high phase: spi_sclk=0, state=HOLD for CLK_DIV cycles with spi_cs_n=0.
REQ-024 HOLD→GAP transition, first GAP cycle: spi_cs_n=1, wr_done=1 for one cycle, trp_out=1 for TRP_LEN cycles if the latched TRP=1, otherwise trp_out stays 0.
REQ-025 GAP SHALL last TRP_LEN cycles; at its end: pending valid → SETUP, otherwise → IDLE.
REQ-026 spi_cs_n SHALL stay low for exactly (66*CLK_DIV) cycles per frame (SETUP + SHIFT + HOLD).
REQ-027 Pending slot (one deep): received_done while state≠IDLE, or while pending is valid, SHALL load the pending slot if it is empty or being consumed in that cycle.
REQ-028 received_done while the pending slot is full and not being consumed: request dropped, overflow=1 for one cycle, pending contents unchanged.
REQ-029 GAP end with pending valid coincident with received_done: pending is started, the new request enters the pending slot, no overflow.
REQ-030 busy SHALL equal (state≠IDLE) OR pending valid.
REQ-031 Bit and half-period counters SHALL use the widths of CLK_DIV and 6 bits respectively, with no wrap within a frame.

Reset
REQ-032 sys_rst=1 SHALL asynchronously force state=IDLE, spi_cs_n=1, spi_sclk=0, spi_mosi=0, trp_out=0, busy=0, wr_done=0, overflow=0, pending cleared, frame latch cleared.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with no wr_done or trp_out; after release the block is in IDLE and accepts the next received_done.

Verification (CLK_DIV=4, TRP_LEN=8)
REQ-034 Single frame, Adress=2'b01, Mod_SEL=6'h2A, D=24'hA5F00F, TRP=0 -> 32 bits sampled on SCLK rising edges = 32'h6AA5F00F; spi_cs_n low for 264 cycles; wr_done once; trp_out stays 0.
REQ-035 Same frame with TRP=1 -> trp_out high for exactly 8 cycles starting on the cs_n rising cycle; the next frame's cs_n falls no earlier than 8 cycles later.
REQ-036 Three received_done pulses 10 cycles apart (IDLE start) -> first frame sent, second held pending and sent after GAP, third drops with overflow=1 once; exactly 2 wr_done pulses.
REQ-037 received_done on the last GAP cycle with pending valid -> pending frame starts, new request becomes pending, overflow=0, then 3 frames total are emitted.
REQ-038 sys_rst asserted at bit 12 of SHIFT -> spi_cs_n=1 and spi_sclk=0 within the same cycle (asynchronous); no wr_done; the next request after release sends a complete, correct frame.
